// File: rtl/bank_req_arb.sv
// bank_req_arb / bank_req_arb_fifo
//   Per-bank request arbiter that sits in front of bank_htu. Each of the 4
//   crossbar channels has its own small FIFO. Every cycle one non-empty FIFO
//   is picked round-robin and loaded into a registered valid/ready output
//   stage.
// Ports (bank_req_arb):
//   clk_i, rst_i                  clock, synchronous active-high reset
//   ch_req_valid_i/ready_o [4]    per-channel push handshake
//   ch_req_opcode_i [8]           {ch3..ch0} x 2b
//   ch_req_addr_i [112]           {ch3..ch0} x addr[31:4]
//   ch_req_wbuffer_id_i [32]      {ch3..ch0} x 8b
//   xbar_bank_htu_*               registered request to bank_htu

// One channel FIFO. The pointers carry an extra wrap bit, so full and empty
// are told apart without a separate counter.
module bank_req_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wp, r_rp;

  assign o_empty = (r_wp == r_rp);
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_data  = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk_i) begin
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_data;
  end
endmodule

module bank_req_arb #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [3:0]   ch_req_valid_i,
  output logic [3:0]   ch_req_ready_o,
  input  logic [7:0]   ch_req_opcode_i,
  input  logic [111:0] ch_req_addr_i,
  input  logic [31:0]  ch_req_wbuffer_id_i,
  output logic         xbar_bank_htu_valid_o,
  input  logic         xbar_bank_htu_ready_i,
  output logic [1:0]   xbar_bank_htu_ch_id_o,
  output logic [1:0]   xbar_bank_htu_opcode_o,
  output logic [27:0]  xbar_bank_htu_addr_o,
  output logic [7:0]   xbar_bank_htu_wbuffer_id_o
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [27:0] addr;
    logic [7:0]  wbuffer_id;
  } req_t;

  localparam int DW = $bits(req_t);

  logic [NUM_LANES-1:0]         w_push, w_pop, w_full, w_empty, w_nempty;
  logic [NUM_LANES-1:0][DW-1:0] w_fifo_q;
  logic [1:0]                   w_win;
  logic                         w_found, w_out_free, w_load;
  req_t                         w_win_req;

  logic       r_valid;
  logic [1:0] r_ch, r_rr_last;
  req_t       r_req;

  // Ready depends only on registered FIFO state (plus reset), so a slot freed
  // by this cycle's pop is not offered until the next cycle.
  assign ch_req_ready_o = ~w_full & {NUM_LANES{~rst_i}};
  assign w_push         = ch_req_valid_i & ch_req_ready_o;
  assign w_nempty       = ~w_empty;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    req_t w_in;
    assign w_in = '{opcode:     ch_req_opcode_i[2*g +: 2],
                    addr:       ch_req_addr_i[28*g +: 28],
                    wbuffer_id: ch_req_wbuffer_id_i[8*g +: 8]};
    assign w_pop[g] = w_load && (w_win == 2'(g));

    bank_req_arb_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_push  (w_push[g]),
      .i_data  (w_in),
      .i_pop   (w_pop[g]),
      .o_data  (w_fifo_q[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Round-robin: scan rr_last+1 .. rr_last+4 (mod 4), first non-empty wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_LANES; k++) begin
      if (!w_found && w_nempty[r_rr_last + 2'(k)]) begin
        w_win   = r_rr_last + 2'(k);
        w_found = 1'b1;
      end
    end
  end

  assign w_win_req  = w_fifo_q[w_win];
  assign w_out_free = !r_valid || xbar_bank_htu_ready_i;
  assign w_load     = w_out_free && w_found;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid   <= 1'b0;
      r_ch      <= '0;
      r_req     <= '0;
      r_rr_last <= 2'd3;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_ch      <= w_win;
      r_req     <= w_win_req;
      r_rr_last <= w_win;
    end else if (xbar_bank_htu_ready_i) begin
      r_valid   <= 1'b0;
    end
  end

  assign xbar_bank_htu_valid_o      = r_valid;
  assign xbar_bank_htu_ch_id_o      = r_ch;
  assign xbar_bank_htu_opcode_o     = r_req.opcode;
  assign xbar_bank_htu_addr_o       = r_req.addr;
  assign xbar_bank_htu_wbuffer_id_o = r_req.wbuffer_id;
endmodule

// File: tb/tb_bank_req_arb.sv
// Directed bench for bank_req_arb: a cycle table of inputs and hand-computed
// outputs, plus hand-written sequences for single-request latency, output
// hold with a full FIFO, and reset in the middle of traffic.
module tb_bank_req_arb;
  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   vld;
  logic [3:0]   rdy_o;
  logic [7:0]   op;
  logic [111:0] addr;
  logic [31:0]  wb;
  logic         o_v, o_rdy;
  logic [1:0]   o_ch, o_op;
  logic [27:0]  o_addr;
  logic [7:0]   o_wb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bank_req_arb #(.FIFO_DEPTH(2)) dut (
    .clk_i(clk), .rst_i(rst),
    .ch_req_valid_i(vld), .ch_req_ready_o(rdy_o),
    .ch_req_opcode_i(op), .ch_req_addr_i(addr), .ch_req_wbuffer_id_i(wb),
    .xbar_bank_htu_valid_o(o_v), .xbar_bank_htu_ready_i(o_rdy),
    .xbar_bank_htu_ch_id_o(o_ch), .xbar_bank_htu_opcode_o(o_op),
    .xbar_bank_htu_addr_o(o_addr), .xbar_bank_htu_wbuffer_id_o(o_wb)
  );

  // Per-channel payload tagged by (channel, tag) so the source of every
  // emitted request is identifiable.
  function automatic logic [37:0] dat(input logic [1:0] ch, input logic [7:0] tag);
    logic [1:0]  d_op;
    logic [27:0] d_addr;
    logic [7:0]  d_wb;
    d_op   = tag[1:0] + ch;
    d_addr = {2'b00, ch, 16'hA5C3, tag};
    d_wb   = {ch, tag[5:0]};
    return {d_op, d_addr, d_wb};
  endfunction

  task automatic drive(input logic [3:0] v, input logic [7:0] tag, input logic r);
    logic [37:0] d;
    vld   = v;
    o_rdy = r;
    for (int i = 0; i < 4; i++) begin
      d = dat(2'(i), tag);
      op[2*i +: 2]    = d[37:36];
      addr[28*i +: 28] = d[35:8];
      wb[8*i +: 8]    = d[7:0];
    end
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] ch, input logic [7:0] tag);
    logic [37:0] d;
    d = dat(ch, tag);
    chk({name, ".valid"}, 64'(o_v), 64'd1);
    chk({name, ".ch"},    64'(o_ch), 64'(ch));
    chk({name, ".op"},    64'(o_op), 64'(d[37:36]));
    chk({name, ".addr"},  64'(o_addr), 64'(d[35:8]));
    chk({name, ".wb"},    64'(o_wb), 64'(d[7:0]));
  endtask

  typedef struct {
    logic [3:0] vld;
    logic [7:0] tag;
    logic       rdy;
    logic       exp_v;
    logic [1:0] exp_ch;
    logic [7:0] exp_tag;
    logic [3:0] exp_rdyo;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] t, input logic r,
                              input logic ev, input logic [1:0] ec, input logic [7:0] et,
                              input logic [3:0] er);
    vec_t x;
    x.vld = v; x.tag = t; x.rdy = r;
    x.exp_v = ev; x.exp_ch = ec; x.exp_tag = et; x.exp_rdyo = er;
    return x;
  endfunction

  initial begin
    // All four channels pushing with ready=1: grants rotate 0,1,2,3 and the
    // depth-2 FIFOs fill, so ready_o follows the single slot freed per pop.
    vecs[0]  = mk(4'hF, 8'd0, 1, 0, 0, 0, 4'hF);
    vecs[1]  = mk(4'hF, 8'd1, 1, 1, 0, 0, 4'h1);
    vecs[2]  = mk(4'hF, 8'd2, 1, 1, 1, 0, 4'h2);
    vecs[3]  = mk(4'hF, 8'd3, 1, 1, 2, 0, 4'h4);
    vecs[4]  = mk(4'hF, 8'd4, 1, 1, 3, 0, 4'h8);
    // ch0 full and popped with valid high: no push, tag5 never enters ch0.
    vecs[5]  = mk(4'hF, 8'd5, 1, 1, 0, 1, 4'h1);
    vecs[6]  = mk(4'hF, 8'd6, 1, 1, 1, 1, 4'h2);
    // Stall: output held, nothing pops.
    vecs[7]  = mk(4'h0, 8'd7, 0, 1, 1, 1, 4'h2);
    vecs[8]  = mk(4'h0, 8'd8, 0, 1, 1, 1, 4'h2);
    // Drain in round-robin order, per-channel order preserved.
    vecs[9]  = mk(4'h0, 8'd9, 1, 1, 2, 1, 4'h6);
    vecs[10] = mk(4'h0, 8'd0, 1, 1, 3, 1, 4'hE);
    vecs[11] = mk(4'h0, 8'd0, 1, 1, 0, 2, 4'hF);
    vecs[12] = mk(4'h0, 8'd0, 1, 1, 1, 3, 4'hF);
    vecs[13] = mk(4'h0, 8'd0, 1, 1, 2, 4, 4'hF);
    vecs[14] = mk(4'h0, 8'd0, 1, 1, 3, 5, 4'hF);
    vecs[15] = mk(4'h0, 8'd0, 1, 1, 0, 6, 4'hF);
    vecs[16] = mk(4'h0, 8'd0, 1, 0, 0, 0, 4'hF);
    // Only ch3 active (rr_last -> 3), then ch0 and ch3 compete and alternate.
    vecs[17] = mk(4'h8, 8'd7, 1, 0, 0, 0, 4'hF);
    vecs[18] = mk(4'h0, 8'd0, 1, 1, 3, 7, 4'hF);
    vecs[19] = mk(4'h9, 8'd8, 1, 0, 0, 0, 4'hF);
    vecs[20] = mk(4'h9, 8'd9, 1, 1, 0, 8, 4'h7);
    vecs[21] = mk(4'h0, 8'd0, 1, 1, 3, 8, 4'hF);
    vecs[22] = mk(4'h0, 8'd0, 1, 1, 0, 9, 4'hF);
    vecs[23] = mk(4'h0, 8'd0, 1, 1, 3, 9, 4'hF);
    vecs[24] = mk(4'h0, 8'd0, 1, 0, 0, 0, 4'hF);

    // Reset
    rst = 1'b1;
    drive(4'h0, 8'd0, 1'b0);
    tick; tick;
    chk("rst.ready_o", 64'(rdy_o), 64'h0);
    chk("rst.valid", 64'(o_v), 64'd0);
    chk("rst.fields", 64'({o_ch, o_op, o_addr, o_wb}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_after", 64'(rdy_o), 64'hF);

    // Table
    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].vld, vecs[i].tag, vecs[i].rdy);
      tick;
      if (vecs[i].exp_v) chk_out($sformatf("vec%0d", i), vecs[i].exp_ch, vecs[i].exp_tag);
      else chk($sformatf("vec%0d.valid", i), 64'(o_v), 64'd0);
      chk($sformatf("vec%0d.ready_o", i), 64'(rdy_o), 64'(vecs[i].exp_rdyo));
    end

    // Single request on ch2: 2-cycle latency, then valid drops.
    drive(4'h0, 8'd0, 1'b1);
    vld = 4'h4;
    op[5:4]    = 2'd1;
    addr[83:56] = 28'h0ABCDE1;
    wb[23:16]  = 8'h5A;
    tick;
    chk("single.lat1", 64'(o_v), 64'd0);
    vld = 4'h0;
    tick;
    chk("single.valid", 64'(o_v), 64'd1);
    chk("single.ch", 64'(o_ch), 64'd2);
    chk("single.op", 64'(o_op), 64'd1);
    chk("single.addr", 64'(o_addr), 64'h0ABCDE1);
    chk("single.wb", 64'(o_wb), 64'h5A);
    tick;
    chk("single.drop", 64'(o_v), 64'd0);

    // ch1 pushes 3 requests while bank_htu stalls.
    drive(4'h2, 8'h31, 1'b0);
    tick;
    chk("hold.push1", 64'(o_v), 64'd0);
    drive(4'h2, 8'h32, 1'b0);
    tick;
    chk_out("hold.first", 2'd1, 8'h31);
    chk("hold.rdy_b", 64'(rdy_o), 64'hF);
    drive(4'h2, 8'h33, 1'b0);
    tick;
    chk("hold.rdy_full", 64'(rdy_o), 64'hD);
    drive(4'h0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk_out($sformatf("hold.c%0d", i), 2'd1, 8'h31);
      chk($sformatf("hold.c%0d.rdy", i), 64'(rdy_o), 64'hD);
    end
    o_rdy = 1'b1;
    tick;
    chk_out("hold.second", 2'd1, 8'h32);
    tick;
    chk_out("hold.third", 2'd1, 8'h33);
    tick;
    chk("hold.drain", 64'(o_v), 64'd0);
    chk("hold.rdy_end", 64'(rdy_o), 64'hF);

    // Reset in the middle of traffic.
    drive(4'hF, 8'h60, 1'b0);
    tick;
    drive(4'h0, 8'h00, 1'b0);
    tick;
    chk("mid.valid_pre", 64'(o_v), 64'd1);
    rst = 1'b1;
    tick;
    chk("mid.valid", 64'(o_v), 64'd0);
    chk("mid.fields", 64'({o_ch, o_op, o_addr, o_wb}), 64'd0);
    chk("mid.ready_in_rst", 64'(rdy_o), 64'h0);
    rst = 1'b0;
    o_rdy = 1'b1;
    #1;
    chk("mid.ready_after", 64'(rdy_o), 64'hF);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("mid.stale%0d", i), 64'(o_v), 64'd0);
    end
    // After reset ch0 has top priority.
    drive(4'h3, 8'h70, 1'b1);
    tick;
    drive(4'h0, 8'h00, 1'b1);
    tick;
    chk_out("mid.prio0", 2'd0, 8'h70);
    tick;
    chk_out("mid.prio1", 2'd1, 8'h70);
    tick;
    chk("mid.idle", 64'(o_v), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
